// File: rtl/cpm_reg_pipe.sv
// DEPTH-stage valid/ready register pipeline for CPM datapath retiming.
// Stalls are absorbed by bubble collapsing; Clear flushes synchronously; Count tracks occupancy.
module cpm_reg_stage #(
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Rstn,
  input  logic [DW-1:0] DataRst,
  input  logic          Clear,
  input  logic [DW-1:0] DataClr,
  input  logic          take,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          vld,
  output logic [DW-1:0] dat
);
  // Data only loads with a valid word, so empty stages keep stale data.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      vld <= 1'b0;
      dat <= DataRst;
    end else if (Clear) begin
      vld <= 1'b0;
      dat <= DataClr;
    end else if (take) begin
      vld <= in_vld;
      if (in_vld) dat <= in_dat;
    end
  end
endmodule

module cpm_reg_pipe #(
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          Clk,
  input  logic          Rstn,
  input  logic [DW-1:0] DataRst,
  input  logic          Clear,
  input  logic [DW-1:0] DataClr,
  input  logic          InVld,
  output logic          InRdy,
  input  logic [DW-1:0] InData,
  output logic          OutVld,
  input  logic          OutRdy,
  output logic [DW-1:0] OutData,
  output logic [CW-1:0] Count
);
  logic [DEPTH-1:0]         vld;
  logic [DEPTH-1:0][DW-1:0] dat;
  logic [DEPTH:0]           rdy;
  logic                     in_xfer, out_xfer;

  // rdy[i]: stage i is free after this edge; chained back from the output so a
  // full pipe with OutRdy high still accepts in the same cycle.
  always_comb begin
    rdy = '0;
    rdy[DEPTH] = OutRdy & ~Clear;
    for (int i = DEPTH-1; i >= 0; i--) rdy[i] = ~vld[i] | rdy[i+1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic          sv;
    logic [DW-1:0] sd;
    if (i == 0) begin : g_head
      assign sv = InVld;
      assign sd = InData;
    end else begin : g_body
      assign sv = vld[i-1];
      assign sd = dat[i-1];
    end
    cpm_reg_stage #(.DW(DW)) u_stg (
      .Clk(Clk), .Rstn(Rstn), .DataRst(DataRst), .Clear(Clear), .DataClr(DataClr),
      .take(rdy[i]), .in_vld(sv), .in_dat(sd), .vld(vld[i]), .dat(dat[i])
    );
  end

  assign InRdy    = rdy[0] & ~Clear;
  assign OutVld   = vld[DEPTH-1] & ~Clear;
  assign OutData  = dat[DEPTH-1];
  assign in_xfer  = InVld & InRdy;
  assign out_xfer = OutVld & OutRdy;

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn)       Count <= '0;
    else if (Clear)  Count <= '0;
    else begin
      case ({in_xfer, out_xfer})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpm_reg_pipe.sv
// Bench for cpm_reg_pipe: DEPTH=3 pipe checked every cycle against a word/position
// queue model, plus directed literal checks; a DEPTH=1 instance is checked directly.
module tb_cpm_reg_pipe;
  localparam int D = 3;
  logic       Clk = 1'b0;
  logic       Rstn, Clear, InVld, OutRdy, InRdy, OutVld;
  logic [7:0] DataRst, DataClr, InData, OutData;
  logic [1:0] Count;
  logic       in1_vld, in1_rdy, out1_vld, out1_rdy;
  logic [7:0] in1_dat, out1_dat;
  logic [0:0] cnt1;
  int         errors = 0, checks = 0;
  bit         started = 0;

  always #5 Clk = ~Clk;

  cpm_reg_pipe #(.DW(8), .DEPTH(D)) u_dut (
    .Clk(Clk), .Rstn(Rstn), .DataRst(DataRst), .Clear(Clear), .DataClr(DataClr),
    .InVld(InVld), .InRdy(InRdy), .InData(InData),
    .OutVld(OutVld), .OutRdy(OutRdy), .OutData(OutData), .Count(Count)
  );

  cpm_reg_pipe #(.DW(8), .DEPTH(1)) u_d1 (
    .Clk(Clk), .Rstn(Rstn), .DataRst(DataRst), .Clear(Clear), .DataClr(DataClr),
    .InVld(in1_vld), .InRdy(in1_rdy), .InData(in1_dat),
    .OutVld(out1_vld), .OutRdy(out1_rdy), .OutData(out1_dat), .Count(cnt1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: ordered words, each with its stage position 0..D-1.
  typedef struct { logic [7:0] d; int p; } ent_t;
  ent_t       q[$];
  logic [7:0] last = 8'hA5;
  bit         m_ix, m_ox;
  int         m_lim;

  function automatic bit m_outvld();
    return !Clear && q.size() > 0 && q[0].p == D-1;
  endfunction

  // Input is accepted if, after every word moves as far as it can, position 0 is free.
  function automatic bit m_inrdy();
    int lim = D;
    int k0  = (m_outvld() && OutRdy) ? 1 : 0;
    if (Clear) return 1'b0;
    for (int k = k0; k < q.size(); k++) lim = (q[k].p + 1 < lim - 1) ? q[k].p + 1 : lim - 1;
    return lim > 0;
  endfunction

  always @(negedge Rstn) begin
    q.delete();
    last = DataRst;
  end

  always @(posedge Clk) begin
    if (!Rstn) begin
      q.delete();
      last = DataRst;
    end else if (Clear) begin
      q.delete();
      last = DataClr;
    end else begin
      m_ix = InVld && m_inrdy();
      m_ox = m_outvld() && OutRdy;
      if (m_ox) void'(q.pop_front());
      m_lim = D;
      foreach (q[k]) begin
        q[k].p = (q[k].p + 1 < m_lim - 1) ? q[k].p + 1 : m_lim - 1;
        m_lim  = q[k].p;
        if (q[k].p == D-1) last = q[k].d;
      end
      if (m_ix) q.push_back('{d: InData, p: 0});
    end
  end

  always @(negedge Clk) begin
    if (started) begin
      chk("cmp_outvld", 32'(OutVld), 32'(m_outvld()));
      chk("cmp_outdata", 32'(OutData), 32'(last));
      chk("cmp_count", 32'(Count), q.size());
      if (Rstn) chk("cmp_inrdy", 32'(InRdy), 32'(m_inrdy()));
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rstn = 1'b0; DataRst = 8'hA5; DataClr = 8'h00; Clear = 1'b0;
    InVld = 1'b0; InData = 8'h00; OutRdy = 1'b0;
    in1_vld = 1'b0; in1_dat = 8'h00; out1_rdy = 1'b0;
    started = 1;
    step(); step();
    #1 chk("rst_outvld", 32'(OutVld), 0); chk("rst_count", 32'(Count), 0);
    chk("rst_outdata", 32'(OutData), 32'hA5);
    Rstn = 1'b1;
    #1 chk("rst_inrdy", 32'(InRdy), 1);

    // streaming
    OutRdy = 1'b1; InVld = 1'b1; InData = 8'h01; step();
    InData = 8'h02; step();
    InData = 8'h03;
    #1 chk("str_novld", 32'(OutVld), 0);
    step(); InData = 8'h04;
    #1 chk("str_vld", 32'(OutVld), 1); chk("str_d1", 32'(OutData), 1); chk("str_cnt", 32'(Count), 3);
    step(); InVld = 1'b0;
    #1 chk("str_d2", 32'(OutData), 2); chk("str_cnt2", 32'(Count), 3);
    step();
    #1 chk("str_d3", 32'(OutData), 3);
    step();
    #1 chk("str_d4", 32'(OutData), 4);
    step();
    #1 chk("str_empty", 32'(OutVld), 0); chk("str_stale", 32'(OutData), 4);

    // backpressure fill
    OutRdy = 1'b0; InVld = 1'b1; InData = 8'h10; step();
    InData = 8'h11; step();
    InData = 8'h12; step();
    InData = 8'h13;
    #1 chk("bp_cnt", 32'(Count), 3); chk("bp_inrdy", 32'(InRdy), 0);
    step();
    #1 chk("bp_hold", 32'(OutData), 32'h10); chk("bp_cnt2", 32'(Count), 3);
    OutRdy = 1'b1;
    #1 chk("bp_pass", 32'(InRdy), 1);
    step(); InVld = 1'b0;
    #1 chk("bp_o11", 32'(OutData), 32'h11);
    step();
    #1 chk("bp_o12", 32'(OutData), 32'h12);
    step();
    #1 chk("bp_o13", 32'(OutData), 32'h13);
    step();
    #1 chk("bp_empty", 32'(OutVld), 0);

    // bubble collapse
    OutRdy = 1'b0; InVld = 1'b1; InData = 8'h20; step();
    InVld = 1'b0; step(); step();
    InVld = 1'b1; InData = 8'h21; step();
    InVld = 1'b0; step();
    #1 chk("bub_cnt", 32'(Count), 2); chk("bub_o20", 32'(OutData), 32'h20);
    OutRdy = 1'b1; step();
    #1 chk("bub_o21", 32'(OutData), 32'h21); chk("bub_vld", 32'(OutVld), 1);
    step();
    #1 chk("bub_empty", 32'(OutVld), 0);

    // clear mid-stream
    OutRdy = 1'b0; InVld = 1'b1; InData = 8'h30; step();
    InData = 8'h31; step();
    InVld = 1'b0; step();
    #1 chk("clr_pre", 32'(OutVld), 1); chk("clr_cnt_pre", 32'(Count), 2);
    Clear = 1'b1; DataClr = 8'h5A; InVld = 1'b1; InData = 8'h32; OutRdy = 1'b1;
    #1 chk("clr_inrdy", 32'(InRdy), 0); chk("clr_outvld", 32'(OutVld), 0);
    step(); Clear = 1'b0; InVld = 1'b0;
    #1 chk("clr_cnt", 32'(Count), 0); chk("clr_data", 32'(OutData), 32'h5A);
    step();
    #1 chk("clr_drop", 32'(Count), 0);

    // reset mid-stream
    OutRdy = 1'b0; InVld = 1'b1; InData = 8'h40; step();
    InData = 8'h41; step();
    InData = 8'h42; step();
    InVld = 1'b0;
    #1 chk("mrst_pre", 32'(Count), 3);
    Rstn = 1'b0;
    #1 chk("mrst_vld", 32'(OutVld), 0); chk("mrst_cnt", 32'(Count), 0);
    chk("mrst_data", 32'(OutData), 32'hA5);
    step(); Rstn = 1'b1; OutRdy = 1'b1;
    step(); step(); step();
    #1 chk("mrst_post", 32'(OutVld), 0); chk("mrst_cnt2", 32'(Count), 0);

    // DEPTH=1 instance
    out1_rdy = 1'b0; in1_vld = 1'b1; in1_dat = 8'h70;
    #1 chk("d1_rdy_empty", 32'(in1_rdy), 1);
    step(); in1_dat = 8'h71;
    #1 chk("d1_full", 32'(in1_rdy), 0); chk("d1_o70", 32'(out1_dat), 32'h70); chk("d1_vld", 32'(out1_vld), 1);
    out1_rdy = 1'b1;
    #1 chk("d1_pass", 32'(in1_rdy), 1);
    step(); in1_dat = 8'h72;
    #1 chk("d1_o71", 32'(out1_dat), 32'h71); chk("d1_cnt", 32'(cnt1), 1);
    step(); in1_dat = 8'h73;
    #1 chk("d1_o72", 32'(out1_dat), 32'h72);
    step(); in1_vld = 1'b0;
    #1 chk("d1_o73", 32'(out1_dat), 32'h73);
    step();
    #1 chk("d1_empty", 32'(out1_vld), 0); chk("d1_cnt0", 32'(cnt1), 0);

    // mixed traffic, checked by the model alone
    repeat (120) begin
      step();
      InVld  = 1'($urandom);
      InData = 8'($urandom);
      OutRdy = ($urandom_range(0, 3) != 0);
      Clear  = ($urandom_range(0, 15) == 0);
    end
    step(); Clear = 1'b0; InVld = 1'b0; OutRdy = 1'b1;
    step(); step(); step(); step();
    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpm_reg_pipe.md
Name: cpm_reg_pipe

Overview:
- Parametrised multi-stage register pipeline that generalises the single reset/clear/enable register into a DEPTH-deep, DW-wide delay line.
- Adds valid/ready flow control, bubble collapsing, synchronous flush and an occupancy count.
- Used between CPM datapath stages wherever a fixed retiming delay must also tolerate downstream stalls.

Parameters:
- DW, 8, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- CW, $clog2(DEPTH+1), width of occupancy count (derived; do not override).

Ports:
- Clk  input  1  clock, all state on rising edge.
- Rstn  input  1  asynchronous, active-low reset.
- DataRst  input  DW  value loaded into every stage data register while Rstn low.
- Clear  input  1  synchronous flush.
- DataClr  input  DW  value loaded into every stage data register on Clear.
- InVld  input  1  upstream word valid.
- InRdy  output  1  pipeline can accept InData this cycle.
- InData  input  DW  upstream word.
- OutVld  output  1  stage DEPTH-1 holds a valid word.
- OutRdy  input  1  downstream accepts OutData this cycle.
- OutData  output  DW  data of stage DEPTH-1.
- Count  output  CW  number of valid stages, 0..DEPTH.

Behaviour:
- Reset (Rstn low, async): all vld[i]=0, all dat[i]=DataRst, Count=0, OutVld=0. InRdy=1 once Rstn is high.
- Stage i holds vld[i] and dat[i]. Stage DEPTH-1 drives OutVld/OutData.
- Move enables (combinational, evaluated from the last stage backwards):
  - mv[DEPTH] = OutRdy.
  - adv[i] = ~vld[i] | mv[i+1] for stage i able to take a new word.
  - Stage i transfers forward when vld[i] & adv[i+1], where the "next" of the last stage is the output port.
- InRdy = adv[0] & ~Clear. Input transfer: InVld & InRdy. Output transfer: OutVld & OutRdy.
- Data rule: dat[i] loads only when stage i receives a valid word, so it is unchanged otherwise. Empty stages keep their stale data.
- OutData is stable while OutVld & ~OutRdy.
- Bubble collapsing: an empty stage always accepts from its predecessor even if downstream is stalled, so a stall fills all DEPTH stages before InRdy drops.
- Latency: with OutRdy held 1, a word accepted at edge t is on OutVld/OutData after edge t+DEPTH-1, i.e. visible DEPTH cycles after it was presented.
- Throughput: 1 word/cycle sustained.
- Full: Count==DEPTH with OutRdy=0 -> InRdy=0. Full with OutRdy=1 -> InRdy=1 in the same cycle (pass-through ready chain, no lost cycle).
- Empty: Count==0 -> OutVld=0, and OutData keeps its last value.
- Count: +1 on an input transfer only, -1 on an output transfer only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Clear (synchronous, highest priority after reset):
  - In the Clear cycle, InRdy=0 and OutVld is forced to 0, so no transfer occurs on either side.
  - Next edge: all vld=0, all dat=DataClr, Count=0.
  - InVld during Clear is dropped; upstream sees InRdy=0.
- Reset asserted mid-stream: all contents are discarded immediately (async) and nothing is emitted afterwards.
- Clear and OutRdy simultaneous: no output transfer.
- DEPTH=1 is legal: single register with the same handshake. InRdy = ~vld[0] | OutRdy.

Test Plan:
- Reset: DW=8, DEPTH=3, DataRst=0xA5, Rstn low for 2 cycles -> OutVld=0, Count=0, OutData=0xA5. After release, InRdy=1.
- Streaming: OutRdy=1, InVld=1 with 0x01,0x02,0x03,0x04 on consecutive cycles -> OutVld rises 3 cycles after the first word. Outputs are 0x01..0x04 on consecutive cycles, Count steady at 3 in mid-stream, no gaps.
- Backpressure fill: OutRdy=0, push 0x10,0x11,0x12,0x13 -> first three are accepted, Count=3, InRdy=0 on the fourth and 0x13 is held. OutData=0x10 stays stable. Raise OutRdy -> 0x13 is accepted that same cycle and the order 0x10,0x11,0x12,0x13 is preserved.
- Bubble collapse: 0x20, a 2-cycle gap, then 0x21, with OutRdy=0 -> Count=2, words adjacent in stages 2 and 1. Release OutRdy -> 0x20 then 0x21 on consecutive cycles.
- Clear mid-stream: Count=2, DataClr=0x5A, Clear=1 with InVld=1 and OutRdy=1 -> InRdy=0 and OutVld=0 in that cycle. Next cycle Count=0 and OutData=0x5A. The input word is not captured.
- Reset mid-stream plus DEPTH=1 variant: Rstn pulse with Count=3 -> OutVld=0 immediately and no stale word after release. Separately, with DEPTH=1, a full register and OutRdy=1 -> InRdy=1 with 1 word/cycle throughput.
